iterative_divider: RTL

Multi-cycle RV32M divide/remainder unit in the EX stage, alongside the ALU and its NBitAdder datapath. It takes DIV/DIVU/REM/REMU operands and runs restoring division, one quotient bit per cycle. Each step uses one N+1-bit subtract. The hazard unit holds the pipeline while busy is high; the result goes to EX/MEM when done pulses.

---
 rtl/iterative_divider.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divide/remainder unit: restoring division, one quotient bit per cycle.
// Signed ops run on magnitudes with sign correction applied when the result is loaded.
module iterative_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_result;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_r;
  logic [N-1:0]    r_b;
  logic [CW-1:0]   r_count;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_signed;
  logic [N-1:0]    w_abs_a;
  logic [N-1:0]    w_abs_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [N-1:0]    w_special_res;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [N:0]      w_rshift;
  logic [N:0]      w_diff;
  logic            w_ge;
  logic [N-1:0]    w_r_nxt;
  logic [N-1:0]    w_q_nxt;
  logic [N-1:0]    w_fin_q;
  logic [N-1:0]    w_fin_r;

  // Operand decode and fast-path detection at the accepting edge
  assign w_signed  = ~op[0];
  assign w_abs_a   = (w_signed && A[N-1]) ? ('0 - A) : A;
  assign w_abs_b   = (w_signed && B[N-1]) ? ('0 - B) : B;
  assign w_b_zero  = (B == '0);
  assign w_ovf     = w_signed && (A == MIN_NEG) && (B == ALL_ONES);
  assign w_special = w_b_zero || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = op[1] ? A : ALL_ONES;
    end else begin
      w_special_res = op[1] ? '0 : A;
    end
  end

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_step   = (r_state == S_RUN) && !flush;
  assign w_last   = w_step && (r_count == CW'(1));

  // One restoring step; the borrow out of bit N says whether R' < |B|
  assign w_rshift = {r_r, r_q[N-1]};
  assign w_diff   = w_rshift - {1'b0, r_b};
  assign w_ge     = ~w_diff[N];
  assign w_r_nxt  = w_ge ? w_diff[N-1:0] : w_rshift[N-1:0];
  assign w_q_nxt  = {r_q[N-2:0], w_ge};
  assign w_fin_q  = r_neg_q ? ('0 - w_q_nxt) : w_q_nxt;
  assign w_fin_r  = r_neg_r ? ('0 - w_r_nxt) : w_r_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Flush beats both acceptance and completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == CW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_r      <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_is_rem <= op[1];
      r_neg_q  <= w_signed && (A[N-1] ^ B[N-1]);
      r_neg_r  <= w_signed && A[N-1];
      r_b      <= w_abs_b;
      r_q      <= w_abs_a;
      r_r      <= '0;
      r_count  <= CW'(N);
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (w_step) begin
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_count <= r_count - CW'(1);
      if (w_last) begin
        r_result <= r_is_rem ? w_fin_r : w_fin_q;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
